// File: rtl/adpll_pkg.sv
// Shared types and helpers for the parametrised ADPLL core.
// Lock detection is compiled in only when ADPLL_LOCK_DET_EN is defined.
package adpll_pkg;

    localparam int unsigned GAIN_SH_W = 4;

    typedef enum logic [1:0] {
        PdIdle    = 2'd0,
        PdWaitFb  = 2'd1,
        PdWaitRef = 2'd2
    } pd_state_t;

    // Clamp a sign-extended value into the range of a w-bit two's-complement number.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/adpll_counter_pd.sv
// Counter-based phase detector: synchronises the reference, detects rising edges of
// reference and feedback, and measures their separation in clk cycles.
module adpll_counter_pd
    import adpll_pkg::*;
#(
    parameter int TDC_W = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_ref,
    input  logic                    enable,
    input  logic                    fb_clk,
    output logic signed [TDC_W-1:0] phase_err,
    output logic                    err_valid
);

    localparam logic signed [TDC_W-1:0] CNT_MAX = TDC_W'((1 << (TDC_W - 1)) - 1);
    localparam logic signed [TDC_W-1:0] CNT_MIN = -CNT_MAX;

    logic [1:0]              sync_q, sync_d;
    logic                    ref_prev_q, ref_prev_d;
    logic                    fb_prev_q, fb_prev_d;
    pd_state_t               state_q, state_d;
    logic signed [TDC_W-1:0] cnt_q, cnt_d;
    logic signed [TDC_W-1:0] phase_err_q, phase_err_d;
    logic                    err_valid_q, err_valid_d;
    logic                    ref_r, fb_r;

    assign ref_r = sync_q[1] & ~ref_prev_q;
    assign fb_r  = fb_clk & ~fb_prev_q;

    always_comb begin
        sync_d      = {sync_q[0], clk_ref};
        ref_prev_d  = sync_q[1];
        fb_prev_d   = fb_clk;
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_err_d = phase_err_q;
        err_valid_d = 1'b0;
        if (!enable) begin
            state_d = PdIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                PdIdle: begin
                    if (ref_r && fb_r) begin
                        phase_err_d = '0;
                        err_valid_d = 1'b1;
                    end else if (ref_r) begin
                        state_d = PdWaitFb;
                        cnt_d   = TDC_W'(1);
                    end else if (fb_r) begin
                        state_d = PdWaitRef;
                        cnt_d   = '1;
                    end
                end
                // A second reference edge while waiting is ignored; only fb closes.
                PdWaitFb: begin
                    if (fb_r) begin
                        state_d     = PdIdle;
                        phase_err_d = cnt_q;
                        err_valid_d = 1'b1;
                        cnt_d       = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + TDC_W'(1);
                    end
                end
                PdWaitRef: begin
                    if (ref_r) begin
                        state_d     = PdIdle;
                        phase_err_d = cnt_q;
                        err_valid_d = 1'b1;
                        cnt_d       = '0;
                    end else if (cnt_q != CNT_MIN) begin
                        cnt_d = cnt_q - TDC_W'(1);
                    end
                end
                default: begin
                    state_d = PdIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            ref_prev_q  <= 1'b0;
            fb_prev_q   <= 1'b0;
            state_q     <= PdIdle;
            cnt_q       <= '0;
            phase_err_q <= '0;
            err_valid_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            ref_prev_q  <= ref_prev_d;
            fb_prev_q   <= fb_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_err_q <= phase_err_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign phase_err = phase_err_q;
    assign err_valid = err_valid_q;

endmodule

// File: rtl/adpll_core_param.sv
// Parametrised ADPLL: counter phase detector, saturating PI filter, accumulator DCO and
// feedback divider. Define ADPLL_LOCK_DET_EN to build the lock detector.
module adpll_core_param
    import adpll_pkg::*;
#(
    parameter int W        = 8,
    parameter int TDC_W    = 10,
    parameter int ACC_W    = 16,
    parameter int NDIV_W   = 4,
    parameter int LOCK_N   = 16,
    parameter int LOCK_TOL = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_ref,
    input  logic                    enable,
    input  logic [NDIV_W-1:0]       ndiv,
    input  logic [GAIN_SH_W-1:0]    alpha_sh,
    input  logic [GAIN_SH_W-1:0]    beta_sh,
    input  logic [GAIN_SH_W-1:0]    kdco_sh,
    input  logic [ACC_W-1:0]        dco_offset,
    output logic signed [TDC_W-1:0] phase_err,
    output logic                    err_valid,
    output logic signed [W-1:0]     filter_out,
    output logic signed [W-1:0]     integ_out,
    output logic                    dco_out,
    output logic                    fb_clk,
    output logic                    lock
);

    localparam int SW = TDC_W + W;
    localparam int IW = ACC_W + 1;
    localparam logic signed [IW-1:0] INC_MIN = IW'(1);
    localparam logic signed [IW-1:0] INC_MAX = IW'((1 << (ACC_W - 1)) - 1);

    logic signed [TDC_W-1:0] pd_err;
    logic                    pd_valid;

    logic signed [W-1:0]     integ_q, integ_d;
    logic signed [W-1:0]     filter_q, filter_d;
    logic signed [SW-1:0]    err_ext, integ_sum, prop_sum;
    logic signed [W-1:0]     integ_new, filter_new;

    logic signed [IW-1:0]    inc_raw;
    logic [ACC_W-1:0]        inc;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    dco_q, dco_d;
    logic                    dco_prev_q, dco_prev_d;
    logic [NDIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic                    fb_q, fb_d;
    logic                    dco_rise;

    adpll_counter_pd #(
        .TDC_W (TDC_W)
    ) u_pd (
        .clk       (clk),
        .reset     (reset),
        .clk_ref   (clk_ref),
        .enable    (enable),
        .fb_clk    (fb_q),
        .phase_err (pd_err),
        .err_valid (pd_valid)
    );

    // PI filter: wide arithmetic, then clamp, so the state never wraps.
    always_comb begin
        err_ext    = SW'(pd_err);
        integ_sum  = SW'(integ_q) + (err_ext >>> beta_sh);
        integ_new  = W'(sat_signed(32'(integ_sum), W));
        prop_sum   = SW'(integ_new) + (err_ext >>> alpha_sh);
        filter_new = W'(sat_signed(32'(prop_sum), W));
        integ_d    = integ_q;
        filter_d   = filter_q;
        if (pd_valid && enable) begin
            integ_d  = integ_new;
            filter_d = filter_new;
        end
    end

    // DCO increment is clamped positive and below half-scale so the MSB always toggles.
    always_comb begin
        inc_raw = $signed({1'b0, dco_offset}) + (IW'(filter_q) <<< kdco_sh);
        if (inc_raw < INC_MIN) begin
            inc = INC_MIN[ACC_W-1:0];
        end else if (inc_raw > INC_MAX) begin
            inc = INC_MAX[ACC_W-1:0];
        end else begin
            inc = inc_raw[ACC_W-1:0];
        end
        acc_d = acc_q + inc;
        dco_d = acc_q[ACC_W-1];
    end

    assign dco_rise = dco_q & ~dco_prev_q;

    always_comb begin
        dco_prev_d = dco_q;
        div_cnt_d  = div_cnt_q;
        fb_d       = fb_q;
        if (ndiv == '0) begin
            div_cnt_d = '0;
            fb_d      = dco_q;
        end else if (dco_rise) begin
            // >= lets a reduced ndiv wrap immediately instead of counting through overflow.
            if (div_cnt_q >= ndiv - NDIV_W'(1)) begin
                div_cnt_d = '0;
                fb_d      = ~fb_q;
            end else begin
                div_cnt_d = div_cnt_q + NDIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            integ_q    <= '0;
            filter_q   <= '0;
            acc_q      <= '0;
            dco_q      <= 1'b0;
            dco_prev_q <= 1'b0;
            div_cnt_q  <= '0;
            fb_q       <= 1'b0;
        end else begin
            integ_q    <= integ_d;
            filter_q   <= filter_d;
            acc_q      <= acc_d;
            dco_q      <= dco_d;
            dco_prev_q <= dco_prev_d;
            div_cnt_q  <= div_cnt_d;
            fb_q       <= fb_d;
        end
    end

`ifdef ADPLL_LOCK_DET_EN
    localparam int LCW = $clog2(LOCK_N + 1);
    localparam logic signed [TDC_W-1:0] TOL = TDC_W'(LOCK_TOL);

    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           lock_q, lock_d;
    logic           in_tol;

    assign in_tol = (pd_err <= TOL) && (pd_err >= -TOL);

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        if (!enable) begin
            lock_cnt_d = '0;
            lock_d     = 1'b0;
        end else if (pd_valid) begin
            if (in_tol) begin
                if (lock_cnt_q < LCW'(LOCK_N)) begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                end
                lock_d = (lock_cnt_d == LCW'(LOCK_N));
            end else begin
                lock_cnt_d = '0;
                lock_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    // A bad error or disable drops lock in the very cycle it is seen.
    assign lock = lock_q & enable & ~(pd_valid & ~in_tol);
`else
    logic unused_lock_cfg;
    assign unused_lock_cfg = ^{32'(LOCK_N), 32'(LOCK_TOL)};
    assign lock = 1'b0;
`endif

    assign phase_err  = pd_err;
    assign err_valid  = pd_valid;
    assign filter_out = filter_q;
    assign integ_out  = integ_q;
    assign dco_out    = dco_q;
    assign fb_clk     = fb_q;

endmodule

// File: tb/tb_adpll_core_param.sv
// Directed self-checking bench for adpll_core_param (default parameters).
module tb_adpll_core_param;

    logic              clk = 1'b0;
    logic              reset;
    logic              clk_ref;
    logic              enable;
    logic [3:0]        ndiv;
    logic [3:0]        alpha_sh, beta_sh, kdco_sh;
    logic [15:0]       dco_offset;
    logic signed [9:0] phase_err;
    logic              err_valid;
    logic signed [7:0] filter_out, integ_out;
    logic              dco_out, fb_clk, lock;

    logic              ref_man = 1'b0;
    logic              ref_run = 1'b0;
    int                ref_ph = 0;
    int                shift_req = 0;
    int                shift_done = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign clk_ref = ref_run ? (ref_ph < 48) : ref_man;

    // Reference generator: period 96 clk, stalls while a requested phase shift is pending.
    always @(negedge clk) begin
        if (!ref_run) begin
            ref_ph <= 0;
        end else if (shift_done < shift_req) begin
            shift_done <= shift_done + 1;
        end else begin
            ref_ph <= (ref_ph == 95) ? 0 : ref_ph + 1;
        end
    end

    adpll_core_param dut (
        .clk        (clk),
        .reset      (reset),
        .clk_ref    (clk_ref),
        .enable     (enable),
        .ndiv       (ndiv),
        .alpha_sh   (alpha_sh),
        .beta_sh    (beta_sh),
        .kdco_sh    (kdco_sh),
        .dco_offset (dco_offset),
        .phase_err  (phase_err),
        .err_valid  (err_valid),
        .filter_out (filter_out),
        .integ_out  (integ_out),
        .dco_out    (dco_out),
        .fb_clk     (fb_clk),
        .lock       (lock)
    );

    typedef struct {
        int ndiv;
        int offset;
        int dco_per;
        int fb_per;
    } ol_vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Rising-edge to rising-edge period, skipping the first edge; -1 if it never settles.
    task automatic measure(input bit use_fb, output int per);
        bit prev, cur;
        int rises = 0;
        int t0 = 0;
        per = -1;
        prev = use_fb ? fb_clk : dco_out;
        for (int cyc = 1; cyc < 4000 && rises < 3; cyc++) begin
            @(negedge clk);
            cur = use_fb ? fb_clk : dco_out;
            if (cur && !prev) begin
                rises++;
                if (rises == 2) t0 = cyc;
                if (rises == 3) per = cyc - t0;
            end
            prev = cur;
        end
    endtask

    task automatic wait_fb_rise(input int limit, output bit found);
        bit prev;
        found = 1'b0;
        prev = fb_clk;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (fb_clk && !prev) found = 1'b1;
            prev = fb_clk;
        end
    endtask

    task automatic wait_valid(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (err_valid) found = 1'b1;
        end
    endtask

    // fb rises at edge m0; reference driven after edge m0+ref_dly reaches the PD at m0+ref_dly+3,
    // the next fb edge reaches it at m0+17.
    task automatic pd_case(input string nm, input int ref_dly, input int exp_err,
                           input int exp_integ, input int exp_filter);
        bit ok;
        ndiv = 4'd0; dco_offset = 16'h1000; kdco_sh = 4'd0;
        alpha_sh = 4'd1; beta_sh = 4'd0; enable = 1'b0; ref_man = 1'b0;
        do_reset();
        wait_fb_rise(100, ok);
        check({nm, "_fb_seen"}, int'(ok), 1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        enable = 1'b1;
        repeat (ref_dly - 8) @(posedge clk);
        @(negedge clk);
        ref_man = 1'b1;
        wait_valid(40, ok);
        check({nm, "_valid"}, int'(ok), 1);
        check({nm, "_err"}, int'(phase_err), exp_err);
        @(negedge clk);
        check({nm, "_valid_pulse"}, int'(err_valid), 0);
        check({nm, "_integ"}, int'(integ_out), exp_integ);
        check({nm, "_filter"}, int'(filter_out), exp_filter);
        enable = 1'b0;
        ref_man = 1'b0;
    endtask

    initial begin
        ol_vec_t ol[5];
        int per;
        bit ok;
        int e, ae;
        int small_seen, late_max, lock_seen;

        reset = 1'b1; enable = 1'b0; ndiv = '0;
        alpha_sh = '0; beta_sh = '0; kdco_sh = '0; dco_offset = 16'h1000;

        ol[0] = '{ndiv: 0, offset: 'h1000, dco_per: 16, fb_per: 16};
        ol[1] = '{ndiv: 3, offset: 'h1000, dco_per: 16, fb_per: 96};
        ol[2] = '{ndiv: 1, offset: 'h1000, dco_per: 16, fb_per: 32};
        ol[3] = '{ndiv: 2, offset: 'h2000, dco_per: 8,  fb_per: 32};
        ol[4] = '{ndiv: 5, offset: 'h0800, dco_per: 32, fb_per: 320};

        do_reset();
        check("rst_filter", int'(filter_out), 0);
        check("rst_lock", int'(lock), 0);

        // Open loop periods.
        for (int i = 0; i < 5; i++) begin
            ndiv = 4'(ol[i].ndiv);
            dco_offset = 16'(ol[i].offset);
            enable = 1'b0;
            do_reset();
            measure(1'b0, per);
            check($sformatf("ol%0d_dco_period", i), per, ol[i].dco_per);
            measure(1'b1, per);
            check($sformatf("ol%0d_fb_period", i), per, ol[i].fb_per);
        end

        // Phase detector: err, then integ = err, filter = err + (err >>> 1).
        pd_case("pd_ref_lead5", 9, 5, 5, 7);
        pd_case("pd_coincident", 14, 0, 0, 0);
        pd_case("pd_fb_lead3", 17, -3, -3, -5);

        // Large positive errors with unit gains: integrator and filter pin at +127.
        ndiv = 4'd15; dco_offset = 16'h1000; kdco_sh = 4'd0;
        alpha_sh = 4'd0; beta_sh = 4'd0; enable = 1'b0; ref_man = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wait_fb_rise(1500, ok);
            repeat (70) @(posedge clk);
            @(negedge clk);
            enable = 1'b1;
            ref_man = 1'b1;
            wait_valid(1000, ok);
            check($sformatf("sat%0d_err_range", k),
                  int'(ok && phase_err >= 350 && phase_err <= 450), 1);
            @(negedge clk);
            check($sformatf("sat%0d_integ", k), int'(integ_out), 127);
            check($sformatf("sat%0d_filter", k), int'(filter_out), 127);
            enable = 1'b0;
            ref_man = 1'b0;
        end

        // Mid-run reset held for three cycles.
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_phase_err", int'(phase_err), 0);
        check("midrst_err_valid", int'(err_valid), 0);
        check("midrst_integ", int'(integ_out), 0);
        check("midrst_filter", int'(filter_out), 0);
        check("midrst_dco", int'(dco_out), 0);
        check("midrst_fb", int'(fb_clk), 0);
        check("midrst_pd_idle", int'(dut.u_pd.state_q), 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_acc_first", int'(dut.acc_q), 'h1000);

        // Closed loop.
        ndiv = 4'd3; dco_offset = 16'h0F00; alpha_sh = 4'd1; beta_sh = 4'd3; kdco_sh = 4'd4;
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        ref_run = 1'b1;
        small_seen = 0; late_max = 0; lock_seen = 0;
        for (int c = 0; c < 200 * 96; c++) begin
            @(negedge clk);
            if (lock) lock_seen = 1;
            if (err_valid) begin
                e = int'(phase_err);
                ae = (e < 0) ? -e : e;
                if (ae <= 2) small_seen = 1;
                if (c >= 160 * 96 && ae > late_max) late_max = ae;
            end
        end
        check("cl_err_within_tol", small_seen, 1);
        check("cl_settled_bound", int'(late_max <= 8), 1);
`ifdef ADPLL_LOCK_DET_EN
        check("cl_lock_seen", lock_seen, 1);
        ok = 1'b0;
        for (int c = 0; c < 200 * 96 && !ok; c++) begin
            @(negedge clk);
            if (lock) ok = 1'b1;
        end
        check("lockloss_locked_first", int'(ok), 1);
        shift_req = shift_req + 20;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (err_valid && (phase_err > 2 || phase_err < -2)) begin
                ok = 1'b1;
                check("lockloss_lock_low", int'(lock), 0);
            end
        end
        check("lockloss_bad_err_seen", int'(ok), 1);
`else
        check("lock_tied_low", lock_seen, 0);
`endif
        ref_run = 1'b0;
        enable = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
